flit_link_buffer: RTL and testbench
===================================

FLIT_LINK_BUFFER -- requirements
Module: flit_link_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the FIFO depth in flits; legal values are powers of two, 2..16.
REQ-002 Parameter FLIT_W, default 8, sets the flit width in bits; the framing logic reads only bits [7:6].
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_flit, input, FLIT_W bits: flit from the upstream router down port.
REQ-006 Port in_valid, input, 1 bit: in_flit is valid this cycle.
REQ-007 Port in_ready, output, 1 bit: the buffer accepts a flit this cycle.
REQ-008 Port out_flit, output, FLIT_W bits: head-of-FIFO flit toward the downstream router VC input.
REQ-009 Port out_valid, output, 1 bit: out_flit is valid this cycle.
REQ-010 Port out_ready, input, 1 bit: the downstream stage consumes out_flit this cycle.
REQ-011 Port occupancy, output, clog2(DEPTH)+1 bits: number of flits currently stored.
REQ-012 Port pkt_count, output, 8 bits: number of packets completed on the input side.
REQ-013 Port frame_err, output, 1 bit: sticky framing-violation flag.

Function
REQ-014 Flit type is in_flit[7:6]: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail in one flit).
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-016 in_ready shall be 1 exactly when occupancy < DEPTH, derived combinationally from registered occupancy.
REQ-017 out_valid shall be 1 exactly when occupancy != 0; out_flit shall equal mem[rd_ptr] (first-word fall-through).
REQ-018 There is no bypass path: a flit pushed in cycle N is first visible on out_flit/out_valid in cycle N+1.
REQ-019 On push, in_flit is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH; on pop, rd_ptr increments modulo DEPTH.
REQ-020 Occupancy changes as follows: push only +1; pop only -1; push and pop in the same cycle, no change (legal at any non-full, non-empty level).
REQ-021 When full, in_ready=0, so no push occurs even if a pop happens that cycle; the freed slot is offered in the next cycle.
REQ-022 When empty, out_valid=0 and out_ready is ignored; occupancy never underflows.
REQ-023 Flits are delivered in order with no loss, duplication or modification, including flits that violate framing.
REQ-024 A framing FSM with states IDLE and IN_PKT is evaluated only on push cycles.
REQ-025 FSM transitions from IDLE: HEAD goes to IN_PKT; SINGLE stays in IDLE and increments pkt_count; BODY or TAIL sets frame_err and stays in IDLE.
REQ-026 FSM transitions from IN_PKT: BODY stays in IN_PKT; TAIL goes to IDLE and increments pkt_count; HEAD sets frame_err and stays in IN_PKT (new packet); SINGLE sets frame_err, goes to IDLE and increments pkt_count.
REQ-027 pkt_count wraps from 255 to 0.
REQ-028 frame_err, once set, remains 1 until reset.

Reset
REQ-029 While rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, occupancy=0, FSM=IDLE, pkt_count=0, frame_err=0; FIFO contents need not be cleared.
REQ-030 In the cycle after reset: out_valid=0, in_ready=1, occupancy=0.
REQ-031 Reset asserted mid-packet or with data stored discards all stored flits; a push attempted in the same cycle as rst=1 is not stored.

Verification
REQ-032 After reset, push 8'h45 (HEAD), 8'h12 (BODY), 8'h83 (TAIL) back-to-back with out_ready=0 -> occupancy reaches 3, out_flit=8'h45 from the cycle after the first push, pkt_count=1, frame_err=0.
REQ-033 DEPTH=4, out_ready=0, in_valid=1 for 6 cycles with SINGLE flits 8'hC0..8'hC5 -> in_ready=0 after 4 pushes, occupancy=4; then raise out_ready -> output sequence is C0,C1,C2,C3 and C4 is accepted one cycle after the first pop.
REQ-034 Occupancy 2, in_valid=1 and out_ready=1 continuously for 20 cycles with SINGLE flits -> occupancy stays 2, output is in order with 2-cycle delay, pkt_count=20, read and write pointers wrap with no corruption.
REQ-035 From IDLE push BODY 8'h05 -> frame_err=1 and 8'h05 still appears on out_flit; subsequent valid packets leave frame_err=1.
REQ-036 Push 255 SINGLE packets then one HEAD+TAIL packet -> pkt_count goes 255 then 0.
REQ-037 Push HEAD and BODY, assert rst for one cycle, then push SINGLE 8'hC7 -> out_flit first shows 8'hC7, pkt_count=1, frame_err=0.

Source files
------------

// File: rtl/flit_link_buffer.sv
// flit_link_buffer: first-word-fall-through flit FIFO placed between an upstream
// router down port and a downstream VC input. It also tracks packet framing on
// the input side: it counts completed packets and raises a sticky error flag on
// framing violations. Flits are always stored and forwarded unchanged, even
// when they break framing.
module flit_link_buffer #(
  parameter int DEPTH  = 4,   // power of two, 2..16
  parameter int FLIT_W = 8    // framing type lives in bits [7:6]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               pkt_count,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Flit type encoding in bits [7:6]
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  // Framing FSM states
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_occ;
  logic [0:0]        r_state;
  logic [7:0]        r_pkt_count;
  logic              r_frame_err;

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_ftype;
  logic [0:0]        w_state_nxt;
  logic              w_pkt_done;
  logic              w_ferr;

  // Handshake flags come only from registered occupancy, so there is no
  // combinational path from in_valid/out_ready to the ready/valid outputs.
  // When full, a simultaneous pop does not open a slot until the next cycle.
  assign in_ready  = (r_occ < FULL_LVL);
  assign out_valid = (r_occ != '0);
  assign out_flit  = r_mem[r_rd_ptr];
  assign occupancy = r_occ;
  assign pkt_count = r_pkt_count;
  assign frame_err = r_frame_err;

  assign w_push  = in_valid && in_ready;
  assign w_pop   = out_valid && out_ready;
  assign w_ftype = in_flit[7:6];

  // Storage array: data only, never cleared; a push during reset is dropped
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= in_flit;
    end
  end

  // Read/write pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Framing next-state: only evaluated for flits actually accepted
  always_comb begin
    w_state_nxt = r_state;
    w_pkt_done  = 1'b0;
    w_ferr      = 1'b0;
    if (w_push) begin
      case (r_state)
        ST_IDLE: begin
          case (w_ftype)
            FT_HEAD:   w_state_nxt = ST_IN_PKT;
            FT_SINGLE: w_pkt_done  = 1'b1;
            default:   w_ferr      = 1'b1;   // BODY or TAIL with no open packet
          endcase
        end
        ST_IN_PKT: begin
          case (w_ftype)
            FT_BODY: w_state_nxt = ST_IN_PKT;
            FT_TAIL: begin
              w_state_nxt = ST_IDLE;
              w_pkt_done  = 1'b1;
            end
            FT_HEAD: w_ferr = 1'b1;          // open packet abandoned, new one starts
            default: begin                   // SINGLE inside a packet
              w_ferr      = 1'b1;
              w_state_nxt = ST_IDLE;
              w_pkt_done  = 1'b1;
            end
          endcase
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Framing state, wrapping packet counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pkt_count <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pkt_done) begin
        r_pkt_count <= r_pkt_count + 8'd1;
      end
      if (w_ferr) begin
        r_frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_link_buffer.sv
// Testbench for flit_link_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_flit_link_buffer;

  localparam int DEPTH  = 4;
  localparam int FLIT_W = 8;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        occupancy;
  logic [7:0]        pkt_count;
  logic              frame_err;

  flit_link_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .pkt_count (pkt_count),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: contents as a queue, packet framing as "inside a packet" bit
  logic [7:0] mq[$];
  int         m_pkt   = 0;
  bit         m_err   = 1'b0;
  bit         m_inpkt = 1'b0;
  bit         m_sync  = 1'b0;

  // One clock cycle: apply inputs, compare DUT against the model state,
  // advance the model by the rules, then step past the edge.
  task automatic cycle(input bit r, input bit iv, input logic [7:0] f, input bit ordy,
                       output bit acc, output bit popd, output logic [7:0] pv);
    bit mpush, mpop, starts, ends;
    rst = r; in_valid = iv; in_flit = f; out_ready = ordy;
    #1;
    if (m_sync) begin
      check("mdl_in_ready", in_ready, (mq.size() < DEPTH));
      check("mdl_out_valid", out_valid, (mq.size() > 0));
      check("mdl_occupancy", occupancy, mq.size());
      check("mdl_pkt_count", pkt_count, m_pkt);
      check("mdl_frame_err", frame_err, m_err);
      if (mq.size() > 0) check("mdl_out_flit", out_flit, mq[0]);
    end
    acc  = iv && in_ready && !r;
    popd = out_valid && ordy && !r;
    pv   = out_flit;
    if (r) begin
      mq.delete();
      m_pkt = 0; m_err = 1'b0; m_inpkt = 1'b0; m_sync = 1'b1;
    end else begin
      mpush = iv && (mq.size() < DEPTH);
      mpop  = ordy && (mq.size() > 0);
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        mq.push_back(f);
        starts = (f[7:6] == 2'b01) || (f[7:6] == 2'b11);
        ends   = (f[7:6] == 2'b10) || (f[7:6] == 2'b11);
        if (starts == m_inpkt) m_err = 1'b1;
        if (ends && (m_inpkt || starts)) m_pkt = (m_pkt + 1) % 256;
        m_inpkt = ends ? 1'b0 : (starts ? 1'b1 : m_inpkt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         r;
    bit         iv;
    logic [7:0] f;
    bit         ordy;
    bit         e_ir;
    bit         e_ov;
    bit         chk_f;
    logic [7:0] e_f;
    int         e_occ;
    int         e_pkt;
    bit         e_err;
  } vec_t;

  vec_t vt[15];

  initial begin
    bit         acc, popd;
    logic [7:0] pv;
    logic [7:0] popped[$];
    int         k, first_acc, pre;

    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;

    // Expected values are those seen just after the clock edge the row is applied on
    //          r  iv flit    ordy ir ov chkf exp_f   occ pkt err
    vt[0]  = '{1, 0, 8'h00, 0,   1, 0, 0,  8'h00, 0,  0,  0};
    vt[1]  = '{0, 1, 8'h45, 0,   1, 1, 1,  8'h45, 1,  0,  0};
    vt[2]  = '{0, 1, 8'h12, 0,   1, 1, 1,  8'h45, 2,  0,  0};
    vt[3]  = '{0, 1, 8'h83, 0,   1, 1, 1,  8'h45, 3,  1,  0};
    vt[4]  = '{0, 0, 8'h00, 1,   1, 1, 1,  8'h12, 2,  1,  0};
    vt[5]  = '{0, 0, 8'h00, 1,   1, 1, 1,  8'h83, 1,  1,  0};
    vt[6]  = '{0, 0, 8'h00, 1,   1, 0, 0,  8'h00, 0,  1,  0};
    vt[7]  = '{0, 1, 8'h05, 0,   1, 1, 1,  8'h05, 1,  1,  1};
    vt[8]  = '{0, 1, 8'hC9, 1,   1, 1, 1,  8'hC9, 1,  2,  1};
    vt[9]  = '{0, 0, 8'h00, 1,   1, 0, 0,  8'h00, 0,  2,  1};
    vt[10] = '{1, 0, 8'h00, 0,   1, 0, 0,  8'h00, 0,  0,  0};
    vt[11] = '{0, 1, 8'h45, 0,   1, 1, 1,  8'h45, 1,  0,  0};
    vt[12] = '{0, 1, 8'h12, 0,   1, 1, 1,  8'h45, 2,  0,  0};
    vt[13] = '{1, 1, 8'h83, 0,   1, 0, 0,  8'h00, 0,  0,  0};
    vt[14] = '{0, 1, 8'hC7, 0,   1, 1, 1,  8'hC7, 1,  1,  0};

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].r; in_valid = vt[i].iv; in_flit = vt[i].f; out_ready = vt[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_ir);
      check($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
      check($sformatf("vec%0d_occupancy", i), occupancy, vt[i].e_occ);
      check($sformatf("vec%0d_pkt_count", i), pkt_count, vt[i].e_pkt);
      check($sformatf("vec%0d_frame_err", i), frame_err, vt[i].e_err);
      if (vt[i].chk_f) check($sformatf("vec%0d_out_flit", i), out_flit, vt[i].e_f);
    end

    // Fill to full with SINGLE flits while the output is stalled, then drain
    cycle(1'b1, 1'b0, 8'h00, 1'b0, acc, popd, pv);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 8'hC0 + 8'(k), 1'b0, acc, popd, pv);
      if (acc) k++;
    end
    check("full_accepted", k, 4);
    check("full_in_ready", in_ready, 1'b0);
    check("full_occupancy", occupancy, 4);
    first_acc = -1;
    popped.delete();
    for (int j = 0; j < 8; j++) begin
      cycle(1'b0, (k < 6), 8'hC0 + 8'(k), 1'b1, acc, popd, pv);
      if (popd) popped.push_back(pv);
      if (acc) begin
        if (first_acc < 0) first_acc = j;
        k++;
      end
    end
    check("full_first_accept_cycle", first_acc, 1);
    check("full_pop_count", popped.size(), 6);
    for (int j = 0; j < 6 && j < popped.size(); j++)
      check($sformatf("full_pop%0d", j), popped[j], 8'hC0 + 8'(j));

    // Steady streaming at occupancy 2 with simultaneous push and pop
    cycle(1'b1, 1'b0, 8'h00, 1'b0, acc, popd, pv);
    cycle(1'b0, 1'b1, 8'hD0, 1'b0, acc, popd, pv);
    cycle(1'b0, 1'b1, 8'hD1, 1'b0, acc, popd, pv);
    check("stream_prefill_occ", occupancy, 2);
    pre = int'(pkt_count);
    popped.delete();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1, acc, popd, pv);
      if (popd) popped.push_back(pv);
      check($sformatf("stream_occ%0d", i), occupancy, 2);
    end
    check("stream_pkt_delta", int'(pkt_count) - pre, 20);
    check("stream_pop_count", popped.size(), 20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      check($sformatf("stream_pop%0d", i), popped[i], (i < 2) ? 8'hD0 + 8'(i) : 8'hC0 + 8'(i - 2));

    // Packet counter wrap: 255 SINGLE packets then one HEAD+TAIL packet
    cycle(1'b1, 1'b0, 8'h00, 1'b0, acc, popd, pv);
    for (int i = 0; i < 255; i++)
      cycle(1'b0, 1'b1, 8'hC0 | 8'(i % 64), 1'b1, acc, popd, pv);
    check("wrap_pkt_255", pkt_count, 8'd255);
    cycle(1'b0, 1'b1, 8'h40, 1'b1, acc, popd, pv);
    check("wrap_pkt_after_head", pkt_count, 8'd255);
    cycle(1'b0, 1'b1, 8'h80, 1'b1, acc, popd, pv);
    check("wrap_pkt_0", pkt_count, 8'd0);
    check("wrap_frame_err", frame_err, 1'b0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), acc, popd, pv);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, acc, popd, pv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
